// File: rtl/la_capture_ctrl_if.sv
// Analyzer-side and host-FIFO-side signals of the capture sequencer.
interface la_capture_ctrl_if;
  localparam int unsigned DATA_W = 64;

  logic              la_enable;
  logic              la_wr_en;
  logic [DATA_W-1:0] la_data;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_data_out;

  // Sequencer side: gates the analyzer and writes the host FIFO
  modport master (
    output la_enable,
    output fifo_wr_en,
    output fifo_data_out,
    input  la_wr_en,
    input  la_data,
    input  fifo_full
  );

  // Analyzer + FIFO side
  modport slave (
    input  la_enable,
    input  fifo_wr_en,
    input  fifo_data_out,
    output la_wr_en,
    output la_data,
    output fifo_full
  );
endinterface

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: arm, masked trigger, counted capture, end-of-capture marker.
module la_capture_ctrl #(
  parameter int unsigned TRIG_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [TRIG_W-1:0] trigger_in,
  input  logic [TRIG_W-1:0] trig_mask,
  input  logic [TRIG_W-1:0] trig_pattern,
  input  logic [CNT_W-1:0]  sample_limit,
  la_capture_ctrl_if.master la_if,
  output logic              busy,
  output logic              triggered,
  output logic              overflow,
  output logic              done,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned DATA_W = 64;

  localparam logic [2:0] RSN_NONE  = 3'd0;
  localparam logic [2:0] RSN_LIMIT = 3'd1;
  localparam logic [2:0] RSN_ABORT = 3'd2;
  localparam logic [2:0] RSN_OVF   = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2:0]          reason_q, reason_d;
  logic                triggered_q, triggered_d;
  logic                overflow_q, overflow_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                match_c;
  logic                accept_c;
  logic                drop_c;
  logic                limit_hit_c;
  logic [CNT_W-1:0]    count_inc_c;

  // Event decode shared by next-state and output logic
  always_comb begin
    match_c     = ((trigger_in ^ trig_pattern) & trig_mask) == '0;
    accept_c    = (state_q == S_RUN) && la_if.la_wr_en && !la_if.fifo_full;
    drop_c      = (state_q == S_RUN) && la_if.la_wr_en && la_if.fifo_full;
    count_inc_c = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    limit_hit_c = accept_c && (limit_q != '0) && (count_inc_c == limit_q);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)        state_d = S_IDLE;
        else if (match_c) state_d = S_RUN;
      end
      S_RUN:   if (drop_c || limit_hit_c || abort) state_d = S_FLUSH;
      S_FLUSH: if (!la_if.fifo_full) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    limit_d     = limit_q;
    count_d     = count_q;
    reason_d    = reason_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    wr_d        = 1'b0;
    data_d      = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          limit_d     = sample_limit;
          count_d     = '0;
          reason_d    = RSN_NONE;
          triggered_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      S_ARMED: if (!abort && match_c) triggered_d = 1'b1;
      S_RUN: begin
        if (accept_c) begin
          wr_d    = 1'b1;
          data_d  = la_if.la_data;
          count_d = count_inc_c;
        end
        if (drop_c) begin
          overflow_d = 1'b1;
          reason_d   = RSN_OVF;
        end else if (limit_hit_c) begin
          reason_d = RSN_LIMIT;
        end else if (abort) begin
          reason_d = RSN_ABORT;
        end
      end
      S_FLUSH: begin
        if (!la_if.fifo_full) begin
          wr_d   = 1'b1;
          data_d = {8'hFF, 5'b0, reason_q, 16'h0000, 32'(count_q)};
        end
      end
      default: ;
    endcase
    enable_d = (state_d == S_RUN);
    // busy stays up through the marker cycle so it hands over directly to done
    busy_d   = (state_d == S_ARMED) || (state_d == S_RUN) || (state_d == S_FLUSH) ||
               ((state_q == S_FLUSH) && (state_d == S_DONE));
    done_d   = (state_q == S_DONE) && (state_d == S_DONE);
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_q     <= '0;
      count_q     <= '0;
      reason_q    <= RSN_NONE;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      limit_q     <= limit_d;
      count_q     <= count_d;
      reason_q    <= reason_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign la_if.la_enable     = enable_q;
  assign la_if.fifo_wr_en    = wr_q;
  assign la_if.fifo_data_out = data_q;
  assign busy                = busy_q;
  assign triggered           = triggered_q;
  assign overflow            = overflow_q;
  assign done                = done_q;
  assign word_count          = count_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Randomized scoreboard bench for the capture sequencer.
module tb_la_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] trigger_in = '0;
  logic [31:0] trig_mask = '0;
  logic [31:0] trig_pattern = '0;
  logic [31:0] sample_limit = '0;
  logic        busy, triggered, overflow, done;
  logic [31:0] word_count;

  la_capture_ctrl_if bus ();

  la_capture_ctrl #(.TRIG_W(32), .CNT_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .abort        (abort),
    .trigger_in   (trigger_in),
    .trig_mask    (trig_mask),
    .trig_pattern (trig_pattern),
    .sample_limit (sample_limit),
    .la_if        (bus.master),
    .busy         (busy),
    .triggered    (triggered),
    .overflow     (overflow),
    .done         (done),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // stimulus items for one capture
  logic        it_wr[$];
  logic [63:0] it_dat[$];
  logic        it_full[$];
  logic        it_abt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO-side monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %h want none (cyc %0d)", bus.fifo_data_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (bus.fifo_data_out !== mon_e.data) begin
          bad++;
          $display("FAIL write_data: got %h want %h (cyc %0d)", bus.fifo_data_out, mon_e.data, cyc);
        end
        total++;
        if (cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL write_cycle: got %0d want %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] nonmatch(input logic [31:0] m, input logic [31:0] p);
    return p ^ (m & (~m + 32'd1));
  endfunction

  task automatic idle_inputs();
    arm = 1'b0;
    abort = 1'b0;
    bus.la_wr_en = 1'b0;
    bus.la_data = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic add_item(input logic w, input logic [63:0] d, input logic f, input logic a);
    it_wr.push_back(w);
    it_dat.push_back(d);
    it_full.push_back(f);
    it_abt.push_back(a);
  endtask

  // Called at a negedge; leaves the DUT in ARMED at the following negedge
  task automatic arm_only(input logic [31:0] m, input logic [31:0] p, input logic [31:0] lim);
    trig_mask = m;
    trig_pattern = p;
    sample_limit = lim;
    trigger_in = (m == 0) ? $urandom : nonmatch(m, p);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("busy_after_arm", 64'(busy), 64'd1);
    chk("count_clear_on_arm", 64'(word_count), 64'd0);
    chk("triggered_clear_on_arm", 64'(triggered), 64'd0);
    chk("overflow_clear_on_arm", 64'(overflow), 64'd0);
    chk("done_clear_on_arm", 64'(done), 64'd0);
  endtask

  task automatic fire_trigger(input int delay);
    if (trig_mask != 0) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        chk("enable_before_match", 64'(bus.la_enable), 64'd0);
        chk("triggered_before_match", 64'(triggered), 64'd0);
      end
      trigger_in = trig_pattern ^ ($urandom & ~trig_mask);
      @(negedge clk);
      trigger_in = nonmatch(trig_mask, trig_pattern);
    end else begin
      @(negedge clk);
    end
    chk("enable_after_match", 64'(bus.la_enable), 64'd1);
    chk("triggered_after_match", 64'(triggered), 64'd1);
  endtask

  // Reference: the spec's per-cycle rules applied to the item list as plain arithmetic
  task automatic run_stream(input logic [31:0] lim);
    int n, stop, j, c0, mcyc, kend;
    logic [31:0] cnt;
    logic [2:0]  rsn;
    logic        ovf;
    exp_t        e;
    add_item(1'b0, 64'd0, 1'b0, 1'b1);
    n = it_wr.size();
    c0 = cyc;
    cnt = 0;
    stop = -1;
    rsn = 0;
    ovf = 0;
    for (int i = 0; i < n && stop < 0; i++) begin
      if (it_wr[i] && it_full[i]) begin
        ovf = 1'b1;
        rsn = 3'd3;
        stop = i;
      end else begin
        if (it_wr[i]) begin
          e.data = it_dat[i];
          e.cyc = c0 + 1 + i;
          exp_q.push_back(e);
          cnt = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 1;
        end
        if (it_wr[i] && lim != 0 && cnt == lim) begin
          rsn = 3'd1;
          stop = i;
        end else if (it_abt[i]) begin
          rsn = 3'd2;
          stop = i;
        end
      end
    end
    j = stop + 1;
    while (j < n && it_full[j]) j++;
    mcyc = c0 + 1 + j;
    e.data = {8'hFF, 5'b0, rsn, 16'h0000, cnt};
    e.cyc = mcyc;
    exp_q.push_back(e);
    kend = (n > j + 2) ? n : j + 2;
    for (int k = 0; k <= kend; k++) begin
      if (cyc == c0 + 1 + stop) chk("enable_off_after_stop", 64'(bus.la_enable), 64'd0);
      if (cyc == mcyc) chk("done_low_at_marker", 64'(done), 64'd0);
      if (cyc == mcyc + 1) begin
        chk("done_after_marker", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("enable_in_done", 64'(bus.la_enable), 64'd0);
        chk("overflow_final", 64'(overflow), 64'(ovf));
        chk("triggered_final", 64'(triggered), 64'd1);
        chk("word_count_final", 64'(word_count), 64'(cnt));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      end
      if (k < n) begin
        bus.la_wr_en = it_wr[k];
        bus.la_data = it_dat[k];
        bus.fifo_full = it_full[k];
        abort = it_abt[k];
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    it_wr.delete();
    it_dat.delete();
    it_full.delete();
    it_abt.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m, lim;
    int len;
    exp_t e;
    idle_inputs();
    #3 reset_n = 1'b0;
    #1;
    chk("reset_enable", 64'(bus.la_enable), 64'd0);
    chk("reset_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("reset_data", bus.fifo_data_out, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_count", 64'(word_count), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // limit 4, six back-to-back words: four written, marker reason 1 count 4
    arm_only(32'h14, 32'h14, 32'd4);
    fire_trigger(1);
    for (int i = 0; i < 6; i++) add_item(1'b1, 64'h42 + 64'(i), 1'b0, 1'b0);
    run_stream(32'd4);

    // unlimited, zero mask, ten words then abort
    arm_only(32'h0, 32'h0, 32'd0);
    fire_trigger(0);
    for (int i = 0; i < 10; i++) add_item(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    run_stream(32'd0);

    // FIFO full on the third word, held five cycles
    arm_only(32'hFF00, 32'h3C00, 32'd0);
    fire_trigger(2);
    add_item(1'b1, 64'hA1, 1'b0, 1'b0);
    add_item(1'b1, 64'hA2, 1'b0, 1'b0);
    add_item(1'b1, 64'hA3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add_item(1'b1, 64'hB0 + 64'(i), 1'b1, 1'b0);
    add_item(1'b1, 64'hC0, 1'b0, 1'b0);
    run_stream(32'd0);

    // abort while ARMED: back to idle, nothing written
    arm_only(32'hFF, 32'h5A, 32'd2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("armed_abort_busy", 64'(busy), 64'd0);
    chk("armed_abort_triggered", 64'(triggered), 64'd0);
    chk("armed_abort_done", 64'(done), 64'd0);
    chk("armed_abort_enable", 64'(bus.la_enable), 64'd0);
    repeat (3) @(negedge clk);
    chk("armed_abort_no_write", 64'(exp_q.size()), 64'd0);

    // abort together with the limit-reaching word: reason 1
    arm_only(32'h0, 32'h0, 32'd3);
    fire_trigger(0);
    add_item(1'b1, 64'hD1, 1'b0, 1'b0);
    add_item(1'b1, 64'hD2, 1'b0, 1'b0);
    add_item(1'b1, 64'hD3, 1'b0, 1'b1);
    run_stream(32'd3);

    // reset in the middle of RUN
    arm_only(32'h0, 32'h0, 32'd0);
    fire_trigger(0);
    for (int i = 0; i < 3; i++) begin
      e.data = {$urandom, $urandom};
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      bus.la_wr_en = 1'b1;
      bus.la_data = e.data;
      @(negedge clk);
    end
    bus.la_data = 64'hDEAD;
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_reset_enable", 64'(bus.la_enable), 64'd0);
    chk("midrun_reset_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_triggered", 64'(triggered), 64'd0);
    chk("midrun_reset_count", 64'(word_count), 64'd0);
    chk("midrun_reset_data", bus.fifo_data_out, 64'd0);
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midrun_reset_no_marker", 64'(exp_q.size()), 64'd0);
    arm_only(32'h1, 32'h1, 32'd2);
    fire_trigger(1);
    add_item(1'b1, 64'hE1, 1'b0, 1'b0);
    add_item(1'b0, 64'hE2, 1'b0, 1'b0);
    add_item(1'b1, 64'hE3, 1'b0, 1'b0);
    run_stream(32'd2);

    // randomized captures
    for (int t = 0; t < 12; t++) begin
      m = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      lim = 32'($urandom_range(0, 8));
      arm_only(m, $urandom, lim);
      fire_trigger($urandom_range(0, 3));
      len = $urandom_range(4, 18);
      for (int i = 0; i < len; i++)
        add_item($urandom_range(0, 3) != 0, {$urandom, $urandom},
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      run_stream(lim);
    end

    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
